muldiv_unit: RTL

Iterative signed multiply/divide responder for the multicycle MIPS datapath: it serves the `mult_start`/`div_start` requests issued by the control unit and answers with `ready`/`div_zero`. It drives the HI/LO load values, so the `mult`, `div`, `mfhi` and `mflo` instructions need no other arithmetic hardware. Results are produced by a 32-step radix-2 engine and held stable between operations.

---
 rtl/muldiv_unit.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative signed 32x32 multiply / 32/32 divide responder for
//               the multicycle MIPS datapath. A radix-2 engine performs one
//               shift-add (multiply) or one restoring-divide step per cycle
//               on operand magnitudes. Signs are applied when the result is
//               loaded into HI/LO, and HI/LO then hold until the next result.
// Ports       : clk        - system clock, rising edge
//               reset      - asynchronous reset, active low
//               mult_start - start signed multiply a*b (sampled in IDLE)
//               div_start  - start signed divide a/b (sampled in IDLE)
//               a, b       - 32-bit operands, needed only at the start edge
//               hi, lo     - product[63:32]/[31:0] or remainder/quotient
//               ready      - one-cycle completion pulse
//               div_zero   - one-cycle pulse with ready on divide by zero
//               busy       - high whenever the FSM is not idle
// Options     : MULDIV_EARLY_OUT_EN - multiply ends as soon as the remaining
//               multiplier bits are all zero (results unchanged)
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        mult_start,
  input  logic        div_start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        ready,
  output logic        div_zero,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  count_q, count_d;
  logic [63:0] mcand_q, mcand_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] mplier_q, mplier_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quot_q, quot_d;
  logic [31:0] divisor_q, divisor_d;
  logic        op_mul_q, op_mul_d;
  logic        neg_q, neg_d;          // product / quotient sign
  logic        neg_rem_q, neg_rem_d;  // remainder follows the dividend
  logic        dz_q, dz_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        ready_q, ready_d;
  logic        div_zero_q, div_zero_d;

  logic [31:0] a_mag, b_mag;
  logic [32:0] rem_shift, rem_diff;
  logic [63:0] prod_signed;
  logic [31:0] quot_signed, rem_signed;

  // Magnitudes and sign application. |0x80000000| stays 0x80000000 and is
  // treated as unsigned from here on.
  always_comb begin
    a_mag       = a[31] ? (~a + 32'd1) : a;
    b_mag       = b[31] ? (~b + 32'd1) : b;
    // The partial remainder is always below the divisor (<= 2^31), so its
    // stored form fits 32 bits; the shifted trial value needs the 33rd bit.
    rem_shift   = {rem_q, quot_q[31]};
    rem_diff    = rem_shift - {1'b0, divisor_q};
    prod_signed = neg_q ? (~acc_q + 64'd1) : acc_q;
    quot_signed = neg_q ? (~quot_q + 32'd1) : quot_q;
    rem_signed  = neg_rem_q ? (~rem_q + 32'd1) : rem_q;
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    mcand_d    = mcand_q;
    acc_d      = acc_q;
    mplier_d   = mplier_q;
    rem_d      = rem_q;
    quot_d     = quot_q;
    divisor_d  = divisor_q;
    op_mul_d   = op_mul_q;
    neg_d      = neg_q;
    neg_rem_d  = neg_rem_q;
    dz_d       = dz_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    ready_d    = 1'b0;
    div_zero_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (mult_start || div_start) begin
          op_mul_d  = mult_start;  // multiply wins a tie
          neg_d     = a[31] ^ b[31];
          neg_rem_d = a[31];
          count_d   = 6'd0;
          mcand_d   = {32'd0, a_mag};
          mplier_d  = b_mag;
          acc_d     = 64'd0;
          rem_d     = 32'd0;
          quot_d    = a_mag;       // dividend shifts out of the quotient reg
          divisor_d = b_mag;
          dz_d      = 1'b0;
          if (mult_start) begin
            state_d = S_MUL;
`ifdef MULDIV_EARLY_OUT_EN
            if (b_mag == 32'd0) state_d = S_DONE;
`endif
          end else if (b == 32'd0) begin
            dz_d    = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_DIV;
          end
        end
      end

      S_MUL: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + 6'd1;
        if (count_q == 6'd31) state_d = S_DONE;
`ifdef MULDIV_EARLY_OUT_EN
        // Remaining multiplier bits all zero: nothing more to accumulate.
        if (mplier_q[31:1] == 31'd0) state_d = S_DONE;
`endif
      end

      S_DIV: begin
        if (!rem_diff[32]) begin
          rem_d  = rem_diff[31:0];
          quot_d = {quot_q[30:0], 1'b1};
        end else begin
          rem_d  = rem_shift[31:0];
          quot_d = {quot_q[30:0], 1'b0};
        end
        count_d = count_q + 6'd1;
        if (count_q == 6'd31) state_d = S_DONE;
      end

      default: begin  // S_DONE
        ready_d = 1'b1;
        state_d = S_IDLE;
        if (dz_q) begin
          div_zero_d = 1'b1;  // HI/LO deliberately left untouched
        end else if (op_mul_q) begin
          hi_d = prod_signed[63:32];
          lo_d = prod_signed[31:0];
        end else begin
          hi_d = rem_signed;
          lo_d = quot_signed;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      count_q    <= 6'd0;
      mcand_q    <= 64'd0;
      acc_q      <= 64'd0;
      mplier_q   <= 32'd0;
      rem_q      <= 32'd0;
      quot_q     <= 32'd0;
      divisor_q  <= 32'd0;
      op_mul_q   <= 1'b0;
      neg_q      <= 1'b0;
      neg_rem_q  <= 1'b0;
      dz_q       <= 1'b0;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
      ready_q    <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      mcand_q    <= mcand_d;
      acc_q      <= acc_d;
      mplier_q   <= mplier_d;
      rem_q      <= rem_d;
      quot_q     <= quot_d;
      divisor_q  <= divisor_d;
      op_mul_q   <= op_mul_d;
      neg_q      <= neg_d;
      neg_rem_q  <= neg_rem_d;
      dz_q       <= dz_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      ready_q    <= ready_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign hi       = hi_q;
  assign lo       = lo_q;
  assign ready    = ready_q;
  assign div_zero = div_zero_q;
  assign busy     = (state_q != S_IDLE);

endmodule
`default_nettype wire
